// File: rtl/region_pkg.sv
// Shared definitions for the region serializer.
// Holds the FSM state enum, default geometry and the beats-per-region
// helper used by the top and the testbench-facing interface.
package region_pkg;

  localparam int DEF_MAX_REGIONS = 16;
  localparam int DEF_X_WIDTH     = 9;
  localparam int DEF_Y_WIDTH     = 9;
  localparam int DEF_LANES       = 1;
  localparam int DEF_CLK_DIV     = 10;

  typedef enum logic [2:0] {
    IDLE, FILL, WAIT_RD, LOAD, SHIFT, FINISH
  } state_e;

  // Data beats needed to carry the wider coordinate, LANES bits at a time.
  function automatic int calc_beats(int xw, int yw, int lanes);
    int w;
    w = (xw > yw) ? xw : yw;
    return (w + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/region_serializer_if.sv
// Region push / serial output bundle for region_serializer.
//   push side : in_valid, in_ready, in_x, in_y, in_last, rd_req
//   serial    : ser_clk, ser_valid, ser_last, ser_x, ser_y
//   status    : list_ready, done, overflow
// slave = serializer, master = producer/consumer environment.
// Parameters must match those of the region_serializer instance.
interface region_serializer_if #(
  parameter int X_WIDTH = 9,
  parameter int Y_WIDTH = 9,
  parameter int LANES   = 1
);
  logic               in_valid;
  logic               in_ready;
  logic [X_WIDTH-1:0] in_x;
  logic [Y_WIDTH-1:0] in_y;
  logic               in_last;
  logic               rd_req;
  logic               ser_clk;
  logic               ser_valid;
  logic               ser_last;
  logic [LANES-1:0]   ser_x;
  logic [LANES-1:0]   ser_y;
  logic               list_ready;
  logic               done;
  logic               overflow;

  modport slave (
    input  in_valid, in_x, in_y, in_last, rd_req,
    output in_ready, ser_clk, ser_valid, ser_last, ser_x, ser_y,
           list_ready, done, overflow
  );

  modport master (
    output in_valid, in_x, in_y, in_last, rd_req,
    input  in_ready, ser_clk, ser_valid, ser_last, ser_x, ser_y,
           list_ready, done, overflow
  );
endinterface

// File: rtl/region_beat_gen.sv
// Beat divider: counts 0..CLK_DIV-1 while run is high, held at 0 otherwise.
//   clk, reset : clock, synchronous active-high reset
//   run        : divider enable
//   tick       : last cycle of a beat (divider wraps to 0 on the next edge)
//   ser_clk    : low for the first half of a beat, high for the second half
module region_beat_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick,
  output logic ser_clk
);
  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] div_q, div_d;

  assign tick    = run && (div_q == DW'(CLK_DIV - 1));
  // div_q is 0 whenever run is low, so ser_clk idles low.
  assign ser_clk = (div_q >= DW'(CLK_DIV / 2));

  always_comb begin
    div_d = div_q + 1'b1;
    if (!run || tick) div_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end
endmodule

// File: rtl/region_serializer.sv
// Region list serializer.
// Collects (x,y) regions on a valid/ready push port until in_last, then on
// rd_req streams every region LSB first over LANES-wide x/y lanes, one beat
// per CLK_DIV clocks with a half-duty ser_clk for the consumer.
//   clk, reset : clock, synchronous active-high reset
//   bus        : region_serializer_if.slave (push, serial and status signals)
// Optional: REGION_SER_PARITY_EN appends an even-parity beat to each region.
module region_serializer import region_pkg::*; #(
  parameter int MAX_REGIONS = DEF_MAX_REGIONS,
  parameter int X_WIDTH     = DEF_X_WIDTH,
  parameter int Y_WIDTH     = DEF_Y_WIDTH,
  parameter int LANES       = DEF_LANES,
  parameter int CLK_DIV     = DEF_CLK_DIV
) (
  input logic                clk,
  input logic                reset,
  region_serializer_if.slave bus
);
  localparam int BEATS = calc_beats(X_WIDTH, Y_WIDTH, LANES);
`ifdef REGION_SER_PARITY_EN
  localparam int NB = BEATS + 1;
`else
  localparam int NB = BEATS;
`endif
  localparam int CW   = $clog2(MAX_REGIONS + 1);
  localparam int IW   = (MAX_REGIONS > 1) ? $clog2(MAX_REGIONS) : 1;
  localparam int BW   = $clog2(NB + 1);
  localparam int PADW = BEATS * LANES;

  state_e state_q, state_d;
  logic [CW-1:0]    count_q, count_d, idx_q, idx_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             ovf_q, ovf_d, vld_q, vld_d, last_q, last_d;
  logic [LANES-1:0] sx_q, sx_d, sy_q, sy_d;

  logic [X_WIDTH-1:0] mem_x [MAX_REGIONS];
  logic [Y_WIDTH-1:0] mem_y [MAX_REGIONS];

  logic             xfer, store, tick;
  logic [CW-1:0]    nxt_idx, sel_idx;
  logic [BW-1:0]    nxt_beat, sel_beat;
  logic [X_WIDTH-1:0] rx;
  logic [Y_WIDTH-1:0] ry;
  logic [PADW-1:0]  xp, yp;
  logic [LANES-1:0] bx, by;
  logic             sel_last;

  assign bus.in_ready   = !reset && (state_q == IDLE || state_q == FILL);
  assign bus.list_ready = (state_q == WAIT_RD);
  assign bus.done       = (state_q == FINISH);
  assign bus.overflow   = ovf_q;
  assign bus.ser_valid  = vld_q;
  assign bus.ser_last   = last_q;
  assign bus.ser_x      = sx_q;
  assign bus.ser_y      = sy_q;

  assign xfer  = bus.in_valid && bus.in_ready;
  assign store = xfer && (count_q != CW'(MAX_REGIONS));

  region_beat_gen #(.CLK_DIV(CLK_DIV)) u_beat (
    .clk     (clk),
    .reset   (reset),
    .run     (state_q == SHIFT),
    .tick    (tick),
    .ser_clk (bus.ser_clk)
  );

  // Storage is written only; contents are meaningless until count covers them.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_x[IW'(count_q)] <= bus.in_x;
      mem_y[IW'(count_q)] <= bus.in_y;
    end
  end

  // Beat pointer for the beat to present next: (0,0) from LOAD, otherwise the
  // successor of the beat currently on the lanes.
  always_comb begin
    nxt_beat = beat_q + 1'b1;
    nxt_idx  = idx_q;
    if (beat_q == BW'(NB - 1)) begin
      nxt_beat = '0;
      nxt_idx  = idx_q + 1'b1;
    end
    sel_idx  = (state_q == LOAD) ? '0 : nxt_idx;
    sel_beat = (state_q == LOAD) ? '0 : nxt_beat;
    rx = mem_x[IW'(sel_idx)];
    ry = mem_y[IW'(sel_idx)];
    xp = PADW'(rx);
    yp = PADW'(ry);
    bx = LANES'(xp >> (int'(sel_beat) * LANES));
    by = LANES'(yp >> (int'(sel_beat) * LANES));
`ifdef REGION_SER_PARITY_EN
    if (sel_beat == BW'(BEATS)) begin
      bx = LANES'(^rx);
      by = LANES'(^ry);
    end
`endif
    sel_last = (sel_idx == count_q - 1'b1) && (sel_beat == BW'(NB - 1));
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    last_d  = last_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    case (state_q)
      IDLE: if (xfer) begin
        count_d = CW'(1);
        ovf_d   = 1'b0;
        state_d = bus.in_last ? WAIT_RD : FILL;
      end
      FILL: if (xfer) begin
        if (store) count_d = count_q + 1'b1;
        else       ovf_d   = 1'b1;
        if (bus.in_last) state_d = WAIT_RD;
      end
      WAIT_RD: if (bus.rd_req) state_d = LOAD;
      LOAD: begin
        idx_d   = '0;
        beat_d  = '0;
        vld_d   = 1'b1;
        last_d  = sel_last;
        sx_d    = bx;
        sy_d    = by;
        state_d = SHIFT;
      end
      SHIFT: if (tick) begin
        if (last_q) begin
          vld_d   = 1'b0;
          last_d  = 1'b0;
          sx_d    = '0;
          sy_d    = '0;
          state_d = FINISH;
        end else begin
          idx_d  = nxt_idx;
          beat_d = nxt_beat;
          last_d = sel_last;
          sx_d   = bx;
          sy_d   = by;
        end
      end
      FINISH: begin
        count_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      beat_q  <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end
endmodule

// File: tb/tb_region_serializer.sv
// Bench for region_serializer: DUT 0 (LANES=1, MAX=16, CLK_DIV=4) and
// DUT 1 (LANES=3, MAX=4, CLK_DIV=2). One DUT is active at a time, so a single
// expected-beat queue is shared; the monitor pops it on each ser_clk rise.
module tb_region_serializer;
  import region_pkg::*;

`ifdef REGION_SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct { int x; int y; bit last; } beat_t;

  logic clk = 0, reset = 1;
  always #5 clk = ~clk;

  region_serializer_if #(.X_WIDTH(9), .Y_WIDTH(9), .LANES(1)) bus_a ();
  region_serializer_if #(.X_WIDTH(9), .Y_WIDTH(9), .LANES(3)) bus_b ();

  region_serializer #(.MAX_REGIONS(16), .X_WIDTH(9), .Y_WIDTH(9), .LANES(1), .CLK_DIV(4))
    u_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  region_serializer #(.MAX_REGIONS(4), .X_WIDTH(9), .Y_WIDTH(9), .LANES(3), .CLK_DIV(2))
    u_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  logic       in_valid [2], in_last [2], rd_req [2];
  logic [8:0] in_x [2], in_y [2];
  logic       in_ready [2], ser_clk [2], ser_valid [2], ser_last [2];
  logic       list_ready [2], done [2], overflow [2];
  logic [2:0] ser_x [2], ser_y [2];

  assign bus_a.in_valid = in_valid[0]; assign bus_b.in_valid = in_valid[1];
  assign bus_a.in_last  = in_last[0];  assign bus_b.in_last  = in_last[1];
  assign bus_a.rd_req   = rd_req[0];   assign bus_b.rd_req   = rd_req[1];
  assign bus_a.in_x     = in_x[0];     assign bus_b.in_x     = in_x[1];
  assign bus_a.in_y     = in_y[0];     assign bus_b.in_y     = in_y[1];
  assign in_ready[0]   = bus_a.in_ready;   assign in_ready[1]   = bus_b.in_ready;
  assign ser_clk[0]    = bus_a.ser_clk;    assign ser_clk[1]    = bus_b.ser_clk;
  assign ser_valid[0]  = bus_a.ser_valid;  assign ser_valid[1]  = bus_b.ser_valid;
  assign ser_last[0]   = bus_a.ser_last;   assign ser_last[1]   = bus_b.ser_last;
  assign list_ready[0] = bus_a.list_ready; assign list_ready[1] = bus_b.list_ready;
  assign done[0]       = bus_a.done;       assign done[1]       = bus_b.done;
  assign overflow[0]   = bus_a.overflow;   assign overflow[1]   = bus_b.overflow;
  assign ser_x[0] = 3'(bus_a.ser_x); assign ser_x[1] = bus_b.ser_x;
  assign ser_y[0] = 3'(bus_a.ser_y); assign ser_y[1] = bus_b.ser_y;

  int ncheck = 0, npass = 0;
  beat_t q [$];
  int mx [$], my [$];
  int nbeats = 0;
  logic sck_prev [2] = '{0, 0};

  task automatic chk(input string tag, input longint got, input longint exp);
    ncheck++;
    if (got === exp) npass++;
    else $display("FAIL %s got %0d expected %0d", tag, got, exp);
  endtask

  function automatic beat_t mk_beat(int x, int y, int lanes, int k, bit last);
    beat_t b;
    int nb;
    nb = (9 + lanes - 1) / lanes;
    if (k < nb) begin
      b.x = (x >> (k * lanes)) & ((1 << lanes) - 1);
      b.y = (y >> (k * lanes)) & ((1 << lanes) - 1);
    end else begin
      b.x = $countones(x) & 1;
      b.y = $countones(y) & 1;
    end
    b.last = last;
    return b;
  endfunction

  // Beat monitor: consumer samples on each ser_clk rise.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset && ser_clk[d] && !sck_prev[d]) begin
        beat_t e;
        nbeats++;
        chk("beat_valid", ser_valid[d], 1);
        chk("beat_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("beat_x", ser_x[d], e.x);
          chk("beat_y", ser_y[d], e.y);
          chk("beat_last", ser_last[d], e.last);
        end
      end
      sck_prev[d] = ser_clk[d];
    end
  end

  task automatic push(input int d, input int x, input int y, input bit last);
    int n = 0;
    @(negedge clk);
    chk("in_ready", in_ready[d], 1);
    in_valid[d] = 1; in_x[d] = 9'(x); in_y[d] = 9'(y); in_last[d] = last;
    while (!in_ready[d] && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    if (mx.size() < ((d == 0) ? 16 : 4)) begin mx.push_back(x); my.push_back(y); end
    @(negedge clk);
    in_valid[d] = 0; in_last[d] = 0;
  endtask

  task automatic start(input int d, input bit wait_done);
    int lanes, nb, exp_n, n;
    bit pl;
    lanes = (d == 0) ? 1 : 3;
    nb = (9 + lanes - 1) / lanes + PAR;
    for (int i = 0; i < mx.size(); i++)
      for (int k = 0; k < nb; k++)
        q.push_back(mk_beat(mx[i], my[i], lanes, k, (i == mx.size() - 1) && (k == nb - 1)));
    exp_n = mx.size() * nb;
    mx.delete(); my.delete();
    nbeats = 0;
    @(negedge clk);
    chk("list_ready", list_ready[d], 1);
    rd_req[d] = 1;
    @(negedge clk);
    rd_req[d] = 0;
    @(negedge clk);
    chk("first_beat_2clk", ser_valid[d], 1);
    if (wait_done) begin
      n = 0; pl = 0;
      while (!done[d] && n < 4000) begin pl = ser_last[d]; @(negedge clk); n++; end
      chk("done_seen", done[d], 1);
      chk("last_before_done", pl, 1);
      chk("valid_at_done", ser_valid[d], 0);
      chk("beat_count", nbeats, exp_n);
      chk("queue_drained", q.size(), 0);
      @(negedge clk);
      chk("done_pulse", done[d], 0);
      chk("idle_ready", in_ready[d], 1);
    end
  endtask

  initial begin
    int n, nb_at_rst;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 0; in_last[d] = 0; rd_req[d] = 0; in_x[d] = 0; in_y[d] = 0;
    end
    reset = 1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready[0], 0);
    chk("rst_ser_valid", ser_valid[0], 0);
    chk("rst_ser_last", ser_last[0], 0);
    chk("rst_ser_clk", ser_clk[0], 0);
    chk("rst_ser_x", ser_x[0], 0);
    chk("rst_ser_y", ser_y[0], 0);
    chk("rst_list_ready", list_ready[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_overflow", overflow[0], 0);
    reset = 0;

    // two-region list, 1 lane
    push(0, 5, 3, 0);
    push(0, 300, 17, 1);
    start(0, 1);

    // rd_req during fill is ignored
    push(0, 9, 4, 0);
    @(negedge clk); rd_req[0] = 1;
    @(negedge clk); rd_req[0] = 0;
    repeat (4) @(negedge clk);
    chk("fill_no_list_ready", list_ready[0], 0);
    chk("fill_no_valid", ser_valid[0], 0);
    push(0, 1, 2, 1);
    chk("held_list_ready", list_ready[0], 1);
    repeat (10) @(negedge clk);
    chk("held_no_valid", ser_valid[0], 0);
    start(0, 1);

    // overflow: 18 pushes into 16 entries
    for (int i = 0; i < 18; i++) push(0, (i * 37 + 11) & 511, (i * 91 + 5) & 511, i == 17);
    chk("overflow_set", overflow[0], 1);
    start(0, 1);
    chk("overflow_sticky", overflow[0], 1);

    // single region (parity shape when enabled)
    push(0, 7, 1, 1);
    chk("overflow_cleared", overflow[0], 0);
    start(0, 1);

    // random list
    for (int i = 0; i < 3; i++) push(0, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), i == 2);
    start(0, 1);

    // reset in the middle of region 0
    push(0, 5, 3, 0);
    push(0, 300, 17, 1);
    start(0, 0);
    n = 0;
    while (nbeats < 4 && n < 200) begin @(negedge clk); n++; end
    chk("reached_beat4", nbeats >= 4, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst_mid_valid", ser_valid[0], 0);
    chk("rst_mid_list_ready", list_ready[0], 0);
    q.delete();
    nb_at_rst = nbeats;
    repeat (30) @(negedge clk);
    chk("rst_mid_no_beats", nbeats, nb_at_rst);
    push(0, 'h155, 'h0AA, 0);
    push(0, 3, 6, 1);
    start(0, 1);

    // 3 lanes
    push(1, 'h1FF, 'h000, 1);
    start(1, 1);
    push(1, 'h0A5, 'h15A, 0);
    push(1, 'h100, 'h001, 1);
    start(1, 1);

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end
endmodule

// File: doc/region_serializer.md
REGION_SERIALIZER -- requirements
Module: region_serializer

Interface
REQ-001 SHALL have parameter MAX_REGIONS, default 16: region list depth.
REQ-002 SHALL have parameter X_WIDTH, default 9: x coordinate width.
REQ-003 SHALL have parameter Y_WIDTH, default 9: y coordinate width.
REQ-004 SHALL have parameter LANES, default 1: serial bits per beat per coordinate, 1..max(X_WIDTH,Y_WIDTH).
REQ-005 SHALL have parameter CLK_DIV, default 10: clk cycles per beat, even, >=2.
REQ-006 SHALL have port clk, input, 1: clock; all logic on its rising edge, no derived-clock flops.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high.
REQ-008 SHALL have ports in_valid input 1, in_ready output 1, in_x input X_WIDTH, in_y input Y_WIDTH, in_last input 1: region push, transfer when in_valid&in_ready.
REQ-009 SHALL have ports rd_req, input, 1: consumer start request.
REQ-010 SHALL have ports ser_clk, ser_valid, ser_last, output, 1 each: beat clock, beat valid, last beat of list.
REQ-011 SHALL have ports ser_x, ser_y, output, LANES each: serial data lanes.
REQ-012 SHALL have ports list_ready output 1 (list held, awaiting rd_req), done output 1 (one-clk pulse after the last beat), overflow output 1 (sticky until next list starts).

Function
REQ-013 SHALL use states IDLE, FILL, WAIT_RD, LOAD, SHIFT, FINISH.
REQ-014 SHALL assert in_ready only in IDLE and FILL.
REQ-015 IDLE: first transfer stores entry 0, count=1, goes to FILL, clears overflow; if in_last on that transfer, goes to WAIT_RD.
REQ-016 FILL: each transfer stores at index count, count+1; transfer with in_last goes to WAIT_RD.
REQ-017 Transfers when count==MAX_REGIONS SHALL be discarded and set overflow; in_last still ends the fill.
REQ-018 WAIT_RD: list_ready=1; rd_req high for one clk goes to LOAD, beat divider cleared.
REQ-019 Each region SHALL be sent as BEATS=ceil(max(X_WIDTH,Y_WIDTH)/LANES) beats, LSB first, lane i of beat k carries bit k*LANES+i; bits beyond a coordinate width are 0.
REQ-020 Beat timing: divider counts 0..CLK_DIV-1; ser_x/ser_y/ser_valid/ser_last change only when the divider wraps to 0; ser_clk=0 for divider<CLK_DIV/2, else 1; consumer samples on ser_clk rising.
REQ-021 First beat SHALL appear within 2 clk of rd_req; regions follow back-to-back, no idle beats.
REQ-022 ser_last=1 only on the final beat of the final region.
REQ-023 FINISH: ser_valid=0, done pulses one clk, then IDLE; count cleared.
REQ-024 ser_clk SHALL be 0 and divider held at 0 outside LOAD/SHIFT.
REQ-025 rd_req outside WAIT_RD SHALL be ignored.

Reset
REQ-026 reset SHALL force IDLE, count=0, in_ready=0 for the reset cycle, ser_valid=0, ser_last=0, ser_x=ser_y=0, ser_clk=0, list_ready=0, done=0, overflow=0.
REQ-027 reset mid-FILL or mid-SHIFT SHALL discard the list; no further beats.
REQ-028 List storage SHALL NOT require reset.

Configuration
REQ-029 With REGION_SER_PARITY_EN defined, each region SHALL be followed by one extra beat: ser_x[0]=even parity of x, ser_y[0]=even parity of y, other lanes 0; ser_last moves to that beat of the final region.
REQ-030 Without REGION_SER_PARITY_EN, no parity beat and no parity logic.

Structure
REQ-031 Shared package region_pkg SHALL hold the state enum, the BEATS calculation function and default widths.
REQ-032 Beat divider/ser_clk SHALL be a sub-module region_beat_gen (inputs clk, reset, run; outputs tick, ser_clk).

Verification
REQ-033 LANES=1, push (5,3),(300,17) last, rd_req -> 18 beats, x bits 1,0,1,0... of 5 then 300, ser_last on beat 18, done one clk after.
REQ-034 LANES=3, push (0x1FF,0x000) -> 3 beats ser_x=7,7,7, ser_y=0,0,0.
REQ-035 Push 18 regions into MAX_REGIONS=16 -> overflow=1, 16 regions serialized, in_ready high throughout fill.
REQ-036 reset at beat 4 of region 1 -> ser_valid=0 next clk, next list serializes from entry 0.
REQ-037 PARITY_EN, push (7,1) LANES=1 -> 10 beats, beat 10 ser_x=1, ser_y=1, ser_last=1.
REQ-038 rd_req during FILL -> ignored; list_ready and serialization only after in_last and a new rd_req.
